// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, state encoding and helpers for the fetch stage
package fetch_stage_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_BUF  = 2'b01,
        S_DROP = 2'b10
    } fetch_state_t;

    // Instruction addresses are word aligned; low bits of a redirect are ignored.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory read port between fetch stage and imem
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    // Fetch side issues requests and receives data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side answers requests.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, imem request FSM, skid buffer and IF/ID register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    fetch_stage_if.master          imem,
    output logic [INSTR_WIDTH-1:0] instr_id,
    output logic [31:0]            pc4_id,
    output logic                   valid_id,
    output logic                   fetch_busy
);

    fetch_state_t           state;
    logic [31:0]            pc;
    logic [31:0]            drop_addr;
    logic [INSTR_WIDTH-1:0] buf_instr;
    logic [31:0]            buf_pc4;
    logic [31:0]            pc_plus4;

    // Natural 32-bit wrap gives the modulo-2^32 increment.
    assign pc_plus4 = pc + 32'd4;

    // Request is held off during reset and while the skid buffer is occupied;
    // a drop keeps presenting the abandoned address so it never changes mid-request.
    always_comb begin
        imem.imem_req  = ~reset & (state != S_BUF);
        imem.imem_addr = (state == S_DROP) ? drop_addr : pc;
        fetch_busy     = imem.imem_req & ~imem.imem_ready;
    end

    // Fetch FSM with PC, drop address, skid buffer and IF/ID register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop_addr <= 32'h0;
            buf_instr <= NOP_INSTR;
            buf_pc4   <= 32'h0;
            instr_id  <= NOP_INSTR;
            pc4_id    <= 32'h0;
            valid_id  <= 1'b0;
        end else if (branch_taken) begin
            pc        <= word_align(branch_target);
            instr_id  <= NOP_INSTR;
            valid_id  <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc4   <= 32'h0;
            if (state == S_REQ && !imem.imem_ready) begin
                drop_addr <= pc;
                state     <= S_DROP;
            end else if (state == S_DROP && !imem.imem_ready) begin
                // Already dropping: keep the outstanding address on the bus until it completes.
                state <= S_DROP;
            end else begin
                state <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem.imem_ready) begin
                        pc <= pc_plus4;
                        if (stall) begin
                            buf_instr <= imem.imem_rdata;
                            buf_pc4   <= pc_plus4;
                            state     <= S_BUF;
                        end else begin
                            instr_id <= imem.imem_rdata;
                            pc4_id   <= pc_plus4;
                            valid_id <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr_id <= NOP_INSTR;
                        valid_id <= 1'b0;
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        instr_id <= buf_instr;
                        pc4_id   <= buf_pc4;
                        valid_id <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.imem_ready) begin
                        state <= S_REQ;
                    end
                    if (!stall) begin
                        instr_id <= NOP_INSTR;
                        valid_id <= 1'b0;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic        fetch_busy;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem_bus),
        .instr_id      (instr_id),
        .pc4_id        (pc4_id),
        .valid_id      (valid_id),
        .fetch_busy    (fetch_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t v(input logic rst, input logic stl, input logic br,
                               input logic [31:0] tgt, input logic rdy, input logic [31:0] rd,
                               input logic e_req, input logic [31:0] e_addr, input logic e_busy,
                               input logic [31:0] e_instr, input logic [31:0] e_pc4,
                               input logic e_valid);
        vec_t r;
        r.rst = rst; r.stl = stl; r.br = br; r.tgt = tgt; r.rdy = rdy; r.rd = rd;
        r.e_req = e_req; r.e_addr = e_addr; r.e_busy = e_busy;
        r.e_instr = e_instr; r.e_pc4 = e_pc4; r.e_valid = e_valid;
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, settle, then sample.
    task automatic drive(input logic rst, input logic stl, input logic br, input logic [31:0] tgt,
                         input logic rdy, input logic [31:0] rd);
        @(negedge clock);
        reset                = rst;
        stall                = stl;
        branch_taken         = br;
        branch_target        = tgt;
        imem_bus.imem_ready  = rdy;
        imem_bus.imem_rdata  = rd;
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        repeat (2) @(posedge clock);

        //              rst stl br tgt           rdy rd             req addr          busy instr          pc4           vld
        // reset state
        vecs.push_back(v(1, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,        0));
        // zero-wait back-to-back
        vecs.push_back(v(0, 0, 0, 32'h0,         1, 32'h2001_0005,  1, 32'h0,         0, 32'h0,         32'h0,        0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1, 32'h2002_0003,  1, 32'h4,         0, 32'h2001_0005, 32'h4,        1));
        // three wait cycles at 0x8
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h8,         1, 32'h2002_0003, 32'h8,        1));
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h8,         1, 32'h0,         32'h8,        0));
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h8,         1, 32'h0,         32'h8,        0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1, 32'hAAAA_0001,  1, 32'h8,         0, 32'h0,         32'h8,        0));
        // stall while the 0xC response arrives -> skid buffer
        vecs.push_back(v(0, 1, 0, 32'h0,         1, 32'hBBBB_0002,  1, 32'hC,         0, 32'hAAAA_0001, 32'hC,        1));
        vecs.push_back(v(0, 1, 0, 32'h0,         0, 32'h0,          0, 32'h0,         0, 32'hAAAA_0001, 32'hC,        1));
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,         0, 32'hAAAA_0001, 32'hC,        1));
        // branch to 0x40 during outstanding request at 0x10 (ready after 2 more waits)
        vecs.push_back(v(0, 0, 1, 32'h40,        0, 32'h0,          1, 32'h10,        1, 32'hBBBB_0002, 32'h10,       1));
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h10,        1, 32'h0,         32'h10,       0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1, 32'hDEAD_0000,  1, 32'h10,        0, 32'h0,         32'h10,       0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1, 32'h1111_0040,  1, 32'h40,        0, 32'h0,         32'h10,       0));
        // branch and stall together with ready -> flush, no buffer
        vecs.push_back(v(0, 1, 1, 32'h80,        1, 32'h2222_0044,  1, 32'h44,        0, 32'h1111_0040, 32'h44,       1));
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h80,        1, 32'h0,         32'h44,       0));
        // fill the skid buffer, then reset while in it
        vecs.push_back(v(0, 1, 0, 32'h0,         1, 32'h3333_0080,  1, 32'h80,        0, 32'h0,         32'h44,       0));
        vecs.push_back(v(1, 1, 0, 32'h0,         0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h44,       0));
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0,         1, 32'h0,         32'h0,        0));
        vecs.push_back(v(0, 0, 0, 32'h0,         1, 32'h4444_0000,  1, 32'h0,         0, 32'h0,         32'h0,        0));
        vecs.push_back(v(0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h4,         1, 32'h4444_0000, 32'h4,        1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rd);
            chk("imem_req", i, {31'h0, imem_bus.imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk("imem_addr", i, imem_bus.imem_addr, vecs[i].e_addr);
            chk("fetch_busy", i, {31'h0, fetch_busy}, {31'h0, vecs[i].e_busy});
            chk("instr_id", i, instr_id, vecs[i].e_instr);
            chk("pc4_id", i, pc4_id, vecs[i].e_pc4);
            chk("valid_id", i, {31'h0, valid_id}, {31'h0, vecs[i].e_valid});
        end

        // Unaligned redirect to the top word, then PC+4 wraps to zero.
        drive(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0);
        drive(0, 0, 0, 32'h0, 1, 32'h5555_0001);
        chk("wrap_addr", 100, imem_bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_flush", 100, {31'h0, valid_id}, 32'h0);
        drive(0, 1, 0, 32'h0, 1, 32'h6666_0002);
        chk("wrap_instr", 101, instr_id, 32'h5555_0001);
        chk("wrap_pc4", 101, pc4_id, 32'h0);
        chk("wrap_valid", 101, {31'h0, valid_id}, 32'h1);
        chk("wrap_next_addr", 101, imem_bus.imem_addr, 32'h0);

        // Branch out of the skid buffer discards the buffered instruction.
        drive(0, 0, 1, 32'h100, 0, 32'h0);
        chk("buf_req", 102, {31'h0, imem_bus.imem_req}, 32'h0);
        chk("buf_hold_instr", 102, instr_id, 32'h5555_0001);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        chk("buf_br_addr", 103, imem_bus.imem_addr, 32'h100);
        chk("buf_br_req", 103, {31'h0, imem_bus.imem_req}, 32'h1);
        chk("buf_br_instr", 103, instr_id, 32'h0);
        chk("buf_br_valid", 103, {31'h0, valid_id}, 32'h0);
        drive(0, 0, 0, 32'h0, 1, 32'h7777_0100);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        chk("tgt_instr", 104, instr_id, 32'h7777_0100);
        chk("tgt_pc4", 104, pc4_id, 32'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
